// File: rtl/matrix_3x3_median_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_3x3_median_pkg
// Brief    : Shared widths, latency and the 3-input compare helper for the
//            per-channel 3x3 median filter.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_3x3_median_pkg;

  localparam int CH_W    = 8;
  localparam int CH_N    = 3;
  localparam int PIX_W   = CH_W * CH_N;
  localparam int MED_LAT = 3;

  typedef logic [CH_W-1:0] ch_t;

  typedef enum logic [1:0] {
    PICK_MIN = 2'd0,
    PICK_MID = 2'd1,
    PICK_MAX = 2'd2
  } pick_t;

  // Unsigned 3-input order statistic; ties are harmless because equal values are interchangeable.
  function automatic ch_t pick3(input ch_t a, input ch_t b, input ch_t c, input pick_t sel);
    ch_t hi_ab;
    ch_t lo_ab;
    ch_t res;
    hi_ab = (a > b) ? a : b;
    lo_ab = (a > b) ? b : a;
    case (sel)
      PICK_MAX: res = (c > hi_ab) ? c : hi_ab;
      PICK_MIN: res = (c < lo_ab) ? c : lo_ab;
      default:  res = (c > hi_ab) ? hi_ab : ((c < lo_ab) ? lo_ab : c);
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_3x3_median_if.sv
`default_nettype none
// ============================================================================
// Module   : matrix_3x3_median_if
// Brief    : Window-tap input and median pixel-stream output bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface matrix_3x3_median_if;
  import matrix_3x3_median_pkg::*;

  logic             matrix_vld;
  logic [PIX_W-1:0] matrix_11;
  logic [PIX_W-1:0] matrix_12;
  logic [PIX_W-1:0] matrix_13;
  logic [PIX_W-1:0] matrix_21;
  logic [PIX_W-1:0] matrix_22;
  logic [PIX_W-1:0] matrix_23;
  logic [PIX_W-1:0] matrix_31;
  logic [PIX_W-1:0] matrix_32;
  logic [PIX_W-1:0] matrix_33;

  logic             dout_vld;
  logic [PIX_W-1:0] dout;
  logic             dout_sof;
  logic             dout_eol;
  logic             dout_eof;

  modport master (
    output matrix_vld, matrix_11, matrix_12, matrix_13,
           matrix_21, matrix_22, matrix_23,
           matrix_31, matrix_32, matrix_33,
    input  dout_vld, dout, dout_sof, dout_eol, dout_eof
  );

  modport slave (
    input  matrix_vld, matrix_11, matrix_12, matrix_13,
           matrix_21, matrix_22, matrix_23,
           matrix_31, matrix_32, matrix_33,
    output dout_vld, dout, dout_sof, dout_eol, dout_eof
  );

endinterface
`default_nettype wire

// File: rtl/matrix_3x3_median_sort3.sv
`default_nettype none
// ============================================================================
// Module   : median_sort3
// Brief    : Combinational 3-value sorter on one 8-bit channel.
// Revision : 1.0 - initial release
// ============================================================================
module median_sort3
  import matrix_3x3_median_pkg::*;
(
  input  wire [CH_W-1:0] a,
  input  wire [CH_W-1:0] b,
  input  wire [CH_W-1:0] c,
  output wire [CH_W-1:0] hi,
  output wire [CH_W-1:0] mid,
  output wire [CH_W-1:0] lo
);

  assign hi  = pick3(a, b, c, PICK_MAX);
  assign mid = pick3(a, b, c, PICK_MID);
  assign lo  = pick3(a, b, c, PICK_MIN);

endmodule
`default_nettype wire

// File: rtl/matrix_3x3_median.sv
`default_nettype none
// ============================================================================
// Module   : matrix_3x3_median
// Brief    : 3-stage per-channel 3x3 median with frame-position flags.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_3x3_median
  import matrix_3x3_median_pkg::*;
#(
  parameter logic [10:0] COL = 11'd10,
  parameter logic [10:0] ROW = 11'd5
)
(
  input  wire                 clk,
  input  wire                 rst_n,
  matrix_3x3_median_if.slave  mif
);

  localparam logic [10:0] C_COL_LAST = COL - 11'd1;
  localparam logic [10:0] C_ROW_LAST = ROW - 11'd1;

  logic [PIX_W-1:0]   w_tap [3][3];
  logic [PIX_W-1:0]   w_dout;
  logic [MED_LAT-1:0] r_vld_sr;
  logic [10:0]        r_col;
  logic [10:0]        r_row;
  logic               r_sof;
  logic               r_eol;
  logic               r_eof;

  assign w_tap[0][0] = mif.matrix_11;
  assign w_tap[0][1] = mif.matrix_12;
  assign w_tap[0][2] = mif.matrix_13;
  assign w_tap[1][0] = mif.matrix_21;
  assign w_tap[1][1] = mif.matrix_22;
  assign w_tap[1][2] = mif.matrix_23;
  assign w_tap[2][0] = mif.matrix_31;
  assign w_tap[2][1] = mif.matrix_32;
  assign w_tap[2][2] = mif.matrix_33;

  for (genvar ch = 0; ch < CH_N; ch++) begin : g_ch
    for (genvar rw = 0; rw < 3; rw++) begin : g_row
      logic [CH_W-1:0] w_hi;
      logic [CH_W-1:0] w_mid;
      logic [CH_W-1:0] w_lo;
      logic [CH_W-1:0] r_hi;
      logic [CH_W-1:0] r_mid;
      logic [CH_W-1:0] r_lo;

      median_sort3 u_sort (
        .a   (w_tap[rw][0][ch*CH_W +: CH_W]),
        .b   (w_tap[rw][1][ch*CH_W +: CH_W]),
        .c   (w_tap[rw][2][ch*CH_W +: CH_W]),
        .hi  (w_hi),
        .mid (w_mid),
        .lo  (w_lo)
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hi  <= '0;
          r_mid <= '0;
          r_lo  <= '0;
        end else begin
          r_hi  <= w_hi;
          r_mid <= w_mid;
          r_lo  <= w_lo;
        end
      end
    end

    logic [CH_W-1:0] r_s2_lo;
    logic [CH_W-1:0] r_s2_md;
    logic [CH_W-1:0] r_s2_hi;
    logic [CH_W-1:0] r_med;

    // Median of nine = median of (max of row-mins, median of row-mids, min of row-maxes).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s2_lo <= '0;
        r_s2_md <= '0;
        r_s2_hi <= '0;
        r_med   <= '0;
      end else begin
        r_s2_lo <= pick3(g_row[0].r_lo,  g_row[1].r_lo,  g_row[2].r_lo,  PICK_MAX);
        r_s2_md <= pick3(g_row[0].r_mid, g_row[1].r_mid, g_row[2].r_mid, PICK_MID);
        r_s2_hi <= pick3(g_row[0].r_hi,  g_row[1].r_hi,  g_row[2].r_hi,  PICK_MIN);
        r_med   <= pick3(r_s2_lo, r_s2_md, r_s2_hi, PICK_MID);
      end
    end

    assign w_dout[ch*CH_W +: CH_W] = r_med;
  end

  // Counters track the pixel entering stage 3 so flags land in the same cycle as its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_sr <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_sof    <= 1'b0;
      r_eol    <= 1'b0;
      r_eof    <= 1'b0;
    end else begin
      r_vld_sr <= {r_vld_sr[MED_LAT-2:0], mif.matrix_vld};
      if (r_vld_sr[MED_LAT-2]) begin
        r_sof <= (r_col == 11'd0) && (r_row == 11'd0);
        r_eol <= (r_col == C_COL_LAST);
        r_eof <= (r_col == C_COL_LAST) && (r_row == C_ROW_LAST);
        if (r_col == C_COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == C_ROW_LAST) ? 11'd0 : r_row + 11'd1;
        end else begin
          r_col <= r_col + 11'd1;
        end
      end else begin
        r_sof <= 1'b0;
        r_eol <= 1'b0;
        r_eof <= 1'b0;
      end
    end
  end

  assign mif.dout     = w_dout;
  assign mif.dout_vld = r_vld_sr[MED_LAT-1];
  assign mif.dout_sof = r_sof;
  assign mif.dout_eol = r_eol;
  assign mif.dout_eof = r_eof;

endmodule
`default_nettype wire
